// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding and default sizing.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } pipe_state_e;

    localparam int unsigned MD_CYCLES_DEF = 32;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned MD_CNT_W      = 8;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stalls, redirect flushes and multi-cycle mul/div freeze.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_CYCLES = MD_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             md_start,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_busy,
    output logic             md_last,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 2);

    pipe_state_e         state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                flush_ev;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        md_last      = 1'b0;
        flush_ev     = 1'b0;
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;

        if (!rst_n) begin
            // Hold the whole pipe frozen and bubbled while reset is asserted.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_ev    = 1'b1;
                    end else if (md_start) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                        md_busy      = 1'b1;
                        md_cnt_d     = MD_LOAD;
                        state_d      = MD_BUSY;
                    end else if (stall_req) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (jump_id) begin
                        if_id_flush = 1'b1;
                        flush_ev    = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy = 1'b1;
                    if (md_cnt_q == '0) begin
                        // Result leaves EX this cycle; only a load-use stall can still hold the front end.
                        md_last = 1'b1;
                        state_d = RUN;
                        if (stall_req) begin
                            pc_we       = 1'b0;
                            if_id_we    = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end else begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                        md_cnt_d     = md_cnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (~pc_we),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_ev),
        .cnt_o (flush_cnt)
    );

endmodule
